elastic_stage_reg: RTL and testbench

ELASTIC_STAGE_REG -- requirements
Module: elastic_stage_reg

---
 rtl/elastic_stage_reg.sv | 99 +++++++++
 tb/tb_elastic_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/elastic_stage_reg.sv
// Elastic pipeline stage: main entry M drives the output; an optional skid entry S lets
// in_ready come straight from a flop so no combinational path crosses the stage.
module elastic_stage_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      SKID    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  localparam bit HasSkid = (SKID != 0);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             in_fire, out_fire;

  always_comb begin
    in_fire   = in_valid & in_ready;
    out_fire  = m_valid_q & out_ready;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (flush) begin
      // Squash both entries; payload registers keep whatever they hold.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = in_fire;
        if (in_fire) begin
          s_data_d = in_data;
        end
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (HasSkid && in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end

    if (!HasSkid) begin
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= RST_VAL;
      s_valid_q <= 1'b0;
      s_data_q  <= RST_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  generate
    if (HasSkid) begin : g_skid
      // Registered copy of !S.valid so in_ready never depends on out_ready this cycle.
      logic in_ready_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= !s_valid_d;
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !m_valid_q | out_ready;
    end
  endgenerate

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign count     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Bench for elastic_stage_reg: one SKID=1 and one SKID=0 instance share stimulus and are
// compared every cycle against bounded-FIFO queue models, plus directed literal checks.
module tb_elastic_stage_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;

  logic       in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0] out_data1, out_data0;
  logic [1:0] count1, count0;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference FIFOs: capacity 2 (skid) and capacity 1 (no skid).
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  elastic_stage_reg #(.WIDTH(8), .RST_VAL(8'h5A), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .flush(flush),
    .count(count1)
  );

  elastic_stage_reg #(.WIDTH(8), .RST_VAL(8'hC3), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready), .flush(flush),
    .count(count0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update on each rising edge from pre-edge inputs and queue contents.
  initial begin
    bit rdy1, rdy0, of1, of0;
    forever begin
      @(posedge clk);
      rdy1 = (q1.size() < 2);
      rdy0 = (q0.size() == 0) || out_ready;
      of1  = (q1.size() > 0) && out_ready;
      of0  = (q0.size() > 0) && out_ready;
      if (rst || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (of1) void'(q1.pop_front());
        if (in_valid && rdy1) q1.push_back(in_data);
        if (of0) void'(q0.pop_front());
        if (in_valid && rdy0) q0.push_back(in_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("skid_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
        check("skid_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
        check("skid_count", 32'(count1), 32'(q1.size()));
        if (q1.size() > 0) check("skid_out_data", 32'(out_data1), 32'(q1[0]));
        check("noskid_in_ready", 32'(in_ready0), 32'((q0.size() == 0) || out_ready));
        check("noskid_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
        check("noskid_count", 32'(count0), 32'(q0.size()));
        if (q0.size() > 0) check("noskid_out_data", 32'(out_data0), 32'(q0[0]));
      end
    end
  end

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready1", 32'(in_ready1), 1);
    check("rst_in_ready0", 32'(in_ready0), 1);
    check("rst_out_valid1", 32'(out_valid1), 0);
    check("rst_count1", 32'(count1), 0);
    check("rst_out_data1", 32'(out_data1), 'h5A);
    check("rst_out_data0", 32'(out_data0), 'hC3);

    // Single payload with one-cycle latency.
    tick();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("a5_out_valid", 32'(out_valid1), 1);
    check("a5_out_data", 32'(out_data1), 'hA5);
    check("a5_count", 32'(count1), 1);
    tick();
    @(negedge clk);
    check("a5_drain_count", 32'(count1), 0);

    // Fill M and S with out_ready low; third push must stall.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33;
    @(negedge clk);
    check("fill_in_ready", 32'(in_ready1), 0);
    check("fill_count", 32'(count1), 2);
    check("fill_out_data", 32'(out_data1), 'h11);
    tick();
    @(negedge clk);
    check("stall_count", 32'(count1), 2);
    check("stall_out_data", 32'(out_data1), 'h11);

    // Drain in order with no gaps.
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain0_data", 32'(out_data1), 'h11);
    tick();
    @(negedge clk);
    check("drain1_data", 32'(out_data1), 'h22);
    check("drain1_in_ready", 32'(in_ready1), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("drain2_data", 32'(out_data1), 'h33);
    check("drain2_valid", 32'(out_valid1), 1);
    tick();
    @(negedge clk);
    check("drain3_valid", 32'(out_valid1), 0);

    // Flush with both entries full and a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    flush = 1'b1; in_data = 8'h44;
    @(negedge clk);
    check("preflush_count", 32'(count1), 2);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid1), 0);
    check("flush_count", 32'(count1), 0);
    check("flush_count0", 32'(count0), 0);
    repeat (3) tick();

    // Streaming through the single-entry stage.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h60 + i);
      @(negedge clk);
      check("stream_in_ready0", 32'(in_ready0), 1);
      if (i > 0) check("stream_out_data0", 32'(out_data0), 32'(8'h5F + i));
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("stream_backpressure0", 32'(in_ready0), 0);
    check("stream_last_data0", 32'(out_data0), 'h67);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(31) == 0);
      rst       = ($urandom_range(499) == 0);
      tick();
    end

    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
